// File: rtl/vscale_fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches to instruction memory
// and buffers the returned instructions in a small queue for decode.
module vscale_fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_wait,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     imem_badmem_e,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [XLEN-1:0]          deq_inst,
  output logic [XLEN-1:0]          deq_pc,
  output logic                     deq_badmem,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            accept;
  logic            enq;
  logic            deq;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count_q;
  logic [CW:0]     occupancy;

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic            bad_mem  [DEPTH];

  logic            unused_bits;
  assign unused_bits = ^redirect_pc[1:0];

  // Slots already committed: queued entries plus the response still on its way.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
  assign accept    = imem_req & ~imem_wait;
  assign enq       = inflight & ~redirect & ~reset;
  assign deq       = (count_q != '0) & deq_ready & ~redirect & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect)
      state_next = RUN;
    else if (enq && imem_badmem_e)
      state_next = HALT;
  end

  // A faulting response stops fetch in the same cycle it lands.
  always_comb begin
    imem_req = (state == RUN) && !redirect && !reset
               && !(inflight && imem_badmem_e) && (occupancy < DEPTH_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
    end else begin
      inflight <= accept;
      if (accept)
        inflight_pc <= fetch_pc;
      if (redirect)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (accept)
        fetch_pc <= fetch_pc + XLEN'(4);
      if (redirect) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (deq) head <= head + 1'b1;
        case ({enq, deq})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[tail] <= imem_rdata;
      pc_mem[tail]   <= inflight_pc;
      bad_mem[tail]  <= imem_badmem_e;
    end
  end

  assign imem_addr  = fetch_pc;
  assign deq_valid  = ~reset & (count_q != '0);
  assign deq_inst   = inst_mem[head];
  assign deq_pc     = pc_mem[head];
  assign deq_badmem = bad_mem[head];
  assign count      = reset ? '0 : count_q;

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Self-checking bench for vscale_fetch_unit: directed vector table, corner-case
// sequences and a randomized run checked against a queue-based reference model.
module tb_vscale_fetch_unit;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_wait;
  logic [31:0] imem_rdata;
  logic        imem_badmem_e;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        deq_badmem;
  logic [2:0]  count;

  vscale_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
    .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .deq_badmem(deq_badmem), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        badm;
  } entry_t;

  // Reference model: the instruction stream as a plain queue plus one pending response.
  entry_t      q[$];
  logic        pending = 1'b0;
  logic        pend_bad = 1'b0;
  logic [31:0] pend_pc = '0;
  logic [31:0] next_pc = RESET_PC;
  logic        halted = 1'b0;
  logic [31:0] fault_pc = 32'hFFFF_FFFF;
  logic        rand_faults = 1'b0;

  logic        s_req, s_valid, s_badm;
  logic [31:0] s_addr, s_pc;
  logic [2:0]  s_count;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timeout waiting for condition at %0t", name, $time);
  endtask

  // One clock cycle: drive memory response, check outputs against the model, advance model.
  task automatic applyStimulus();
    logic exp_req, exp_valid;
    if (pending) begin
      pend_bad      = (pend_pc == fault_pc) || (rand_faults && $urandom_range(0, 15) == 0);
      imem_rdata    = inst_of(pend_pc);
      imem_badmem_e = pend_bad;
    end else begin
      imem_rdata    = $urandom;
      imem_badmem_e = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = deq_valid;
    s_pc = deq_pc; s_badm = deq_badmem; s_count = count;
    exp_req = !reset && !redirect && !halted && !(pending && pend_bad)
              && (q.size() + int'(pending) < DEPTH);
    exp_valid = !reset && (q.size() != 0);
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", imem_addr, next_pc);
    checkOutput("count", 32'(count), reset ? 32'd0 : 32'(q.size()));
    checkOutput("deq_valid", 32'(deq_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("deq_pc", deq_pc, q[0].pc);
      checkOutput("deq_inst", deq_inst, q[0].inst);
      checkOutput("deq_badmem", 32'(deq_badmem), 32'(q[0].badm));
    end
    if (reset) begin
      q.delete(); pending = 0; halted = 0; next_pc = RESET_PC;
    end else if (redirect) begin
      q.delete(); pending = 0; halted = 0; next_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_valid && deq_ready) void'(q.pop_front());
      if (pending) begin
        q.push_back('{inst: inst_of(pend_pc), pc: pend_pc, badm: pend_bad});
        if (pend_bad) halted = 1;
      end
      if (exp_req && !imem_wait) begin
        pending = 1; pend_pc = next_pc; next_pc = next_pc + 32'd4;
      end else begin
        pending = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    reset = 1; redirect = 0; imem_wait = 0;
    for (int i = 0; i < n; i++) applyStimulus();
    reset = 0;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int hits, reqs;
    logic seen, found;

    reset = 1; redirect = 0; redirect_pc = '0; deq_ready = 1; imem_wait = 0;
    imem_rdata = '0; imem_badmem_e = 0;

    // Free-running fetch then backpressure with a single-cycle drain.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 3'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 3'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 3'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h8, 3'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h8, 3'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h8, 3'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h8, 3'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h8, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'hC, 3'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'hC, 3'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'hC, 3'd4};

    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; deq_ready = vecs[i].rdy; redirect = 0; imem_wait = 0;
      applyStimulus();
      checkOutput($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) checkOutput($sformatf("vec%0d_addr", i), s_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) checkOutput($sformatf("vec%0d_pc", i), s_pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_count", i), 32'(s_count), 32'(vecs[i].exp_count));
    end

    // Stall at 0x10 for three cycles, then exactly one entry for 0x10.
    doReset(1); deq_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (next_pc == 32'h10) found = 1; else applyStimulus();
    end
    if (!found) timeoutFail("wait_setup");
    imem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("wait_req", 32'(s_req), 32'd1);
      checkOutput("wait_addr_hold", s_addr, 32'h10);
    end
    imem_wait = 0;
    applyStimulus();
    checkOutput("wait_release_addr", s_addr, 32'h10);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      if (s_valid && s_pc == 32'h10) hits++;
    end
    checkOutput("wait_single_enq", 32'(hits), 32'd1);

    // Redirect with two queued entries and one response in flight.
    doReset(1); deq_ready = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (q.size() == 2 && pending) found = 1; else applyStimulus();
    end
    if (!found) timeoutFail("redirect_setup");
    redirect = 1; redirect_pc = 32'h203; deq_ready = 1;
    applyStimulus();
    checkOutput("redir_req_low", 32'(s_req), 32'd0);
    redirect = 0;
    applyStimulus();
    checkOutput("redir_count0", 32'(s_count), 32'd0);
    checkOutput("redir_req", 32'(s_req), 32'd1);
    checkOutput("redir_addr", s_addr, 32'h200);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus();
      if (s_valid) begin
        found = 1;
        checkOutput("redir_first_pc", s_pc, 32'h200);
      end
    end
    if (!found) timeoutFail("redirect_first_deq");

    // Access fault on 0x8 halts fetch until a redirect.
    fault_pc = 32'h8;
    doReset(1); deq_ready = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      if (s_valid && s_badm && !seen) begin
        seen = 1;
        checkOutput("fault_pc", s_pc, 32'h8);
      end
    end
    checkOutput("fault_seen", 32'(seen), 32'd1);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (s_req) reqs++;
    end
    checkOutput("halt_no_req", 32'(reqs), 32'd0);
    fault_pc = 32'hFFFF_FFFF;
    redirect = 1; redirect_pc = 32'h40;
    applyStimulus();
    redirect = 0;
    applyStimulus();
    checkOutput("resume_req", 32'(s_req), 32'd1);
    checkOutput("resume_addr", s_addr, 32'h40);

    // Reset with a nearly full queue and a response in flight.
    doReset(1); deq_ready = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (q.size() == 3 && pending) found = 1; else applyStimulus();
    end
    if (!found) timeoutFail("reset_setup");
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("rst_count", 32'(s_count), 32'd0);
      checkOutput("rst_req", 32'(s_req), 32'd0);
      checkOutput("rst_valid", 32'(s_valid), 32'd0);
    end
    reset = 0;
    applyStimulus();
    checkOutput("post_rst_req", 32'(s_req), 32'd1);
    checkOutput("post_rst_addr", s_addr, RESET_PC);
    checkOutput("post_rst_count", 32'(s_count), 32'd0);

    // Randomized traffic against the reference model.
    rand_faults = 1;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      deq_ready   = ($urandom_range(0, 3) != 0);
      imem_wait   = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
